// File: rtl/reg_port_sched.sv
// Register-file port scheduler: shares both RF ports between operand reads and writeback FIFO drains.
// Optional macro REG_PORT_SCHED_BYPASS_EN forwards pending FIFO data to reads instead of stalling them.
module reg_port_sched #(
  parameter int WB_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rd_req_valid_i,
  output logic                        rd_req_ready_o,
  input  logic [4:0]                  rs1_addr_i,
  input  logic [4:0]                  rs2_addr_i,
  output logic                        rd_rsp_valid_o,
  output logic [31:0]                 rs1_data_o,
  output logic [31:0]                 rs2_data_o,
  input  logic                        wb_valid_i,
  output logic                        wb_ready_o,
  input  logic [4:0]                  wb_addr_i,
  input  logic [31:0]                 wb_data_i,
  output logic                        rf_rw1_o,
  output logic                        rf_rw2_o,
  output logic [4:0]                  rf_addr1_o,
  output logic [4:0]                  rf_addr2_o,
  output logic [31:0]                 rf_data1_o,
  output logic [31:0]                 rf_data2_o,
  input  logic [31:0]                 rf_data1_i,
  input  logic [31:0]                 rf_data2_i,
  output logic [$clog2(WB_DEPTH):0]   wb_count_o
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    M_IDLE,
    M_READ,
    M_DRAIN,
    M_FORCED
  } mode_e;

  logic [4:0]    fifo_addr [WB_DEPTH];
  logic [31:0]   fifo_data [WB_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic          vld_p1;
  logic [31:0]   rs1_data_p1;
  logic [31:0]   rs2_data_p1;

  mode_e         mode;
  logic          hit1, hit2;
  logic [31:0]   fwd1, fwd2;
  logic [PW-1:0] idx;
  logic          rd_block;
  logic          drain;
  logic          two_avail;
  logic [1:0]    pop_n;
  logic          push;
  logic [31:0]   op1_p0, op2_p0;
  logic [PW-1:0] next_idx;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= SW'(STARVE_MAX)) return SW'(STARVE_MAX);
    return v + SW'(1);
  endfunction

  // Youngest matching entry wins because later slots overwrite earlier hits.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (fifo_addr[idx] == rs1_addr_i) begin
          hit1 = 1'b1;
          fwd1 = fifo_data[idx];
        end
        if (fifo_addr[idx] == rs2_addr_i) begin
          hit2 = 1'b1;
          fwd2 = fifo_data[idx];
        end
      end
    end
  end

`ifdef REG_PORT_SCHED_BYPASS_EN
  assign rd_block = 1'b0;
  assign op1_p0   = (rs1_addr_i == 5'd0) ? 32'd0 : (hit1 ? fwd1 : rf_data1_i);
  assign op2_p0   = (rs2_addr_i == 5'd0) ? 32'd0 : (hit2 ? fwd2 : rf_data2_i);
`else
  // A read that would see stale RF data yields to a drain instead.
  assign rd_block = rd_req_valid_i &&
                    (((rs1_addr_i != 5'd0) && hit1) || ((rs2_addr_i != 5'd0) && hit2));
  assign op1_p0   = (rs1_addr_i == 5'd0) ? 32'd0 : rf_data1_i;
  assign op2_p0   = (rs2_addr_i == 5'd0) ? 32'd0 : rf_data2_i;
  logic unused_fwd;
  assign unused_fwd = ^{fwd1, fwd2};
`endif

  always_comb begin
    mode = M_IDLE;
    if ((count == CW'(WB_DEPTH)) || (starve == SW'(STARVE_MAX))) mode = M_FORCED;
    else if (rd_req_valid_i && !rd_block)                         mode = M_READ;
    else if (count != '0)                                          mode = M_DRAIN;
  end

  assign drain     = (mode == M_DRAIN) || (mode == M_FORCED);
  assign two_avail = (count > CW'(1));
  assign pop_n     = !drain ? 2'd0 : (two_avail ? 2'd2 : ((count != '0) ? 2'd1 : 2'd0));
  assign next_idx  = rd_ptr + PW'(1);

  assign wb_ready_o     = (count < CW'(WB_DEPTH));
  assign rd_req_ready_o = (mode == M_READ);
  assign push           = wb_valid_i && wb_ready_o && (wb_addr_i != 5'd0);

  // Port drive is forced quiet while reset is held so nothing reaches the RF.
  always_comb begin
    rf_rw1_o   = 1'b0;
    rf_rw2_o   = 1'b0;
    rf_addr1_o = '0;
    rf_addr2_o = '0;
    rf_data1_o = '0;
    rf_data2_o = '0;
    if (rst_ni) begin
      if (mode == M_READ) begin
        rf_addr1_o = rs1_addr_i;
        rf_addr2_o = rs2_addr_i;
      end else if (drain && (count != '0)) begin
        rf_rw1_o   = 1'b1;
        rf_addr1_o = fifo_addr[rd_ptr];
        rf_data1_o = fifo_data[rd_ptr];
        if (two_avail) begin
          rf_rw2_o   = 1'b1;
          rf_addr2_o = fifo_addr[next_idx];
          rf_data2_o = fifo_data[next_idx];
        end
      end
    end
  end

  // Stage p0 -> p1: FIFO/control update and read response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      starve      <= '0;
      vld_p1      <= 1'b0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= wb_addr_i;
        fifo_data[wr_ptr] <= wb_data_i;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);

      if (drain || (count == '0)) starve <= '0;
      else if (mode == M_READ)    starve <= sat_inc(starve);

      vld_p1 <= (mode == M_READ);
      if (mode == M_READ) begin
        rs1_data_p1 <= op1_p0;
        rs2_data_p1 <= op2_p0;
      end
    end
  end

  assign rd_rsp_valid_o = vld_p1;
  assign rs1_data_o     = rs1_data_p1;
  assign rs2_data_o     = rs2_data_p1;
  assign wb_count_o     = count;

endmodule
